fetch_unit: RTL and testbench

- Instruction-fetch stage; the producing end of the IF/ID interface.
- Generates the PC and issues single-outstanding requests to instruction memory.
- Buffers returned words in a 2-entry queue and presents one instruction per cycle to decode.
- Consumes decode's branch-taken/target outputs to redirect, flush and discard in-flight fetches.

---
 rtl/cpu_pkg.sv | 27 ++
 rtl/fetch_queue.sv | 62 ++++++
 rtl/fetch_unit.sv | 158 +++++++++++++++
 tb/tb_fetch_unit.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared CPU definitions used by the fetch stage and its instruction queue.
// Contents:
//   ADDR_W, INST_W    - byte-address and instruction widths
//   PC_STEP           - byte increment between sequential instructions
//   NOP_INST          - word presented to decode when nothing is valid
//   fetch_state_e     - fetch FSM states {IDLE, REQ, FULL}
//   fetch_entry_t     - one queue entry {pc, inst}
package cpu_pkg;

  localparam int ADDR_W = 16;
  localparam int INST_W = 32;

  localparam logic [ADDR_W-1:0] PC_STEP  = 16'd4;
  localparam logic [INST_W-1:0] NOP_INST = 32'h0000_0000;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    FULL = 2'd2
  } fetch_state_e;

  typedef struct packed {
    logic [ADDR_W-1:0] pc;
    logic [INST_W-1:0] inst;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_queue.sv
// Two-entry FIFO of fetched {pc, inst} pairs sitting between instruction
// memory and decode.
// Ports:
//   clk, reset      - clock, synchronous active-high reset
//   push_i          - write {push_pc_i, push_inst_i}; accepted when not full,
//                     or when full and a pop happens in the same cycle
//   pop_i           - remove the head entry (ignored when empty)
//   flush_i         - discard every entry; dominates push and pop
//   count_o         - number of valid entries (0..2)
//   head_pc_o       - pc of the head entry (meaningless when empty)
//   head_inst_o     - instruction of the head entry (meaningless when empty)
module fetch_queue
  import cpu_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              push_i,
  input  logic [ADDR_W-1:0] push_pc_i,
  input  logic [INST_W-1:0] push_inst_i,
  input  logic              pop_i,
  input  logic              flush_i,
  output logic [1:0]        count_o,
  output logic [ADDR_W-1:0] head_pc_o,
  output logic [INST_W-1:0] head_inst_o
);

  fetch_entry_t mem_q [2];
  logic         rd_ptr_q;
  logic         wr_ptr_q;
  logic [1:0]   count_q;

  logic do_pop;
  logic do_push;

  assign do_pop  = pop_i && (count_q != 2'd0);
  // A full queue still takes a push if the head leaves in the same cycle.
  assign do_push = push_i && ((count_q != 2'd2) || do_pop);

  always_ff @(posedge clk) begin
    if (reset || flush_i) begin
      rd_ptr_q <= 1'b0;
      wr_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      if (do_push) wr_ptr_q <= ~wr_ptr_q;
      if (do_pop)  rd_ptr_q <= ~rd_ptr_q;
      count_q <= count_q + 2'(do_push) - 2'(do_pop);
    end
  end

  // Storage needs no reset: count_q alone decides what is valid.
  always_ff @(posedge clk) begin
    if (do_push && !flush_i) begin
      mem_q[wr_ptr_q] <= '{pc: push_pc_i, inst: push_inst_i};
    end
  end

  assign count_o     = count_q;
  assign head_pc_o   = mem_q[rd_ptr_q].pc;
  assign head_inst_o = mem_q[rd_ptr_q].inst;

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: generates the PC, issues one outstanding request
// at a time to instruction memory, buffers responses in a 2-entry queue and
// presents one instruction per cycle to decode. A taken branch from decode
// flushes the queue, redirects the PC and discards any in-flight response.
// Optional build macro: FETCH_PERF_CNT_EN adds perf_fetched / perf_flushed /
// perf_stall counter outputs.
// Ports:
//   clk, reset           - clock, synchronous active-high reset
//   imem_req/imem_addr   - fetch request, held until imem_rdy
//   imem_rdy/imem_rdata  - response strobe and instruction word
//   br_taken/br_target   - redirect from decode (highest priority after reset)
//   stall                - decode hold; keeps the presented instruction
//   if_inst/if_pc/if_valid - instruction presented to decode
//   dbg_state            - current fetch FSM state
//   perf_*               - (FETCH_PERF_CNT_EN only) free-running counters
// Handshake: a request is outstanding while imem_req=1; imem_addr is stable
// for that whole time and the request completes on the cycle imem_rdy=1.
// Decode consumes if_inst on any cycle with if_valid=1 and stall=0.
module fetch_unit
  import cpu_pkg::*;
#(
  parameter logic [ADDR_W-1:0] RESET_PC = 16'h0000
) (
  input  logic              clk,
  input  logic              reset,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_rdy,
  input  logic [INST_W-1:0] imem_rdata,
  input  logic              br_taken,
  input  logic [ADDR_W-1:0] br_target,
  input  logic              stall,
  output logic [INST_W-1:0] if_inst,
  output logic [ADDR_W-1:0] if_pc,
  output logic              if_valid,
  output fetch_state_e      dbg_state
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0]       perf_fetched,
  output logic [31:0]       perf_flushed,
  output logic [31:0]       perf_stall
`endif
);

  fetch_state_e      state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic              drop_q, drop_d;
  logic [ADDR_W-1:0] drop_addr_q, drop_addr_d;

  logic              q_push;
  logic              q_pop;
  logic [1:0]        q_count;
  logic [1:0]        count_next;
  logic [ADDR_W-1:0] head_pc;
  logic [INST_W-1:0] head_inst;
  logic              accept;

  fetch_queue u_queue (
    .clk         (clk),
    .reset       (reset),
    .push_i      (q_push),
    .push_pc_i   (imem_addr),
    .push_inst_i (imem_rdata),
    .pop_i       (q_pop),
    .flush_i     (br_taken),
    .count_o     (q_count),
    .head_pc_o   (head_pc),
    .head_inst_o (head_inst)
  );

  assign imem_req = (state_q == REQ);
  // While a dropped response is still owed, keep pointing at the address
  // that was actually requested; the redirect target waits in pc_q.
  assign imem_addr = drop_q ? drop_addr_q : pc_q;
  assign accept    = imem_req && imem_rdy;

  // A response coinciding with br_taken belongs to the squashed path.
  assign q_push = accept && !drop_q && !br_taken;
  assign q_pop  = if_valid && !stall && !br_taken;

  assign count_next = q_count + 2'(q_push) - 2'(q_pop);

  assign if_valid  = (q_count != 2'd0);
  assign if_inst   = if_valid ? head_inst : NOP_INST;
  assign if_pc     = if_valid ? head_pc : '0;
  assign dbg_state = state_q;

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    drop_d      = drop_q;
    drop_addr_d = drop_addr_q;
    if (br_taken) begin
      pc_d        = br_target;
      state_d     = REQ;
      // An outstanding request not completing now must have its response
      // swallowed later; one completing now is simply not pushed.
      drop_d      = imem_req && !imem_rdy;
      drop_addr_d = imem_addr;
    end else begin
      case (state_q)
        IDLE: state_d = REQ;
        REQ: begin
          if (accept) begin
            if (drop_q) begin
              drop_d = 1'b0;
            end else begin
              pc_d = pc_q + PC_STEP;
              if (count_next == 2'd2) state_d = FULL;
            end
          end
        end
        FULL: begin
          // Resume in the cycle right after a pop so a stream never gaps.
          if (count_next != 2'd2) state_d = REQ;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      pc_q        <= RESET_PC;
      drop_q      <= 1'b0;
      drop_addr_q <= RESET_PC;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      drop_q      <= drop_d;
      drop_addr_q <= drop_addr_d;
    end
  end

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] perf_fetched_q;
  logic [31:0] perf_flushed_q;
  logic [31:0] perf_stall_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      perf_fetched_q <= '0;
      perf_flushed_q <= '0;
      perf_stall_q   <= '0;
    end else begin
      if (q_push)            perf_fetched_q <= perf_fetched_q + 32'd1;
      if (br_taken)          perf_flushed_q <= perf_flushed_q + 32'd1;
      if (if_valid && stall) perf_stall_q   <= perf_stall_q + 32'd1;
    end
  end

  assign perf_fetched = perf_fetched_q;
  assign perf_flushed = perf_flushed_q;
  assign perf_stall   = perf_stall_q;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit. Instruction memory is modelled either as
// zero-wait (imem_rdy follows imem_req) or as a hand-driven imem_rdy; every
// returned word is tagged with its address as {16'hC0DE, addr}.
module tb_fetch_unit;
  import cpu_pkg::*;

  logic              clk;
  logic              reset;
  logic              imem_req;
  logic [ADDR_W-1:0] imem_addr;
  logic              imem_rdy;
  logic [INST_W-1:0] imem_rdata;
  logic              br_taken;
  logic [ADDR_W-1:0] br_target;
  logic              stall;
  logic [INST_W-1:0] if_inst;
  logic [ADDR_W-1:0] if_pc;
  logic              if_valid;
  fetch_state_e      dbg_state;
`ifdef FETCH_PERF_CNT_EN
  logic [31:0]       perf_fetched;
  logic [31:0]       perf_flushed;
  logic [31:0]       perf_stall;
`endif

  logic zero_wait;
  logic rdy_man;

  int n_cmp;
  int n_err;

  logic [ADDR_W-1:0] exp_q[$];

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- memory model ----------------
  assign imem_rdy   = zero_wait ? imem_req : rdy_man;
  assign imem_rdata = {16'hC0DE, imem_addr};

  fetch_unit dut (
    .clk        (clk),
    .reset      (reset),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_rdy   (imem_rdy),
    .imem_rdata (imem_rdata),
    .br_taken   (br_taken),
    .br_target  (br_target),
    .stall      (stall),
    .if_inst    (if_inst),
    .if_pc      (if_pc),
    .if_valid   (if_valid),
    .dbg_state  (dbg_state)
`ifdef FETCH_PERF_CNT_EN
    ,
    .perf_fetched (perf_fetched),
    .perf_flushed (perf_flushed),
    .perf_stall   (perf_stall)
`endif
  );

  // ---------------- driver / checker tasks ----------------
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic check_front(input string tag, input logic [ADDR_W-1:0] pc);
    check({tag, "_valid"}, 32'(if_valid), 32'd1);
    check({tag, "_pc"}, 32'(if_pc), 32'(pc));
    check({tag, "_inst"}, if_inst, {16'hC0DE, pc});
  endtask

  task automatic check_empty(input string tag);
    check({tag, "_valid"}, 32'(if_valid), 32'd0);
    check({tag, "_nop"}, if_inst, NOP_INST);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    n_cmp     = 0;
    n_err     = 0;
    reset     = 1'b1;
    stall     = 1'b0;
    br_taken  = 1'b0;
    br_target = '0;
    zero_wait = 1'b1;
    rdy_man   = 1'b0;

    repeat (3) tick();
    // Reset values.
    check("rst_req", 32'(imem_req), 32'd0);
    check("rst_addr", 32'(imem_addr), 32'h0000);
    check("rst_ifpc", 32'(if_pc), 32'h0000);
    check_empty("rst");
    check("rst_state", 32'(dbg_state), 32'(IDLE));

    // Release: one IDLE cycle, then a REQ cycle, then instructions.
    reset = 1'b0;
    check("rel_idle_req", 32'(imem_req), 32'd0);
    tick();
    check("rel_req", 32'(imem_req), 32'd1);
    check("rel_addr0", 32'(imem_addr), 32'h0000);
    check_empty("rel_c1");
    tick();
    check_front("seq0", 16'h0000);
    check("seq_addr4", 32'(imem_addr), 32'h0004);
    tick();
    check_front("seq4", 16'h0004);
    check("seq_addr8", 32'(imem_addr), 32'h0008);
    tick();
    check_front("seq8", 16'h0008);

    // Stall while 8 is presented: queue fills with {8,12}, fetch parks.
    stall = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("stall_pc", 32'(if_pc), 32'h0008);
      check("stall_req", 32'(imem_req), 32'd0);
    end
    check("stall_state", 32'(dbg_state), 32'(FULL));
    stall = 1'b0;
    exp_q = '{16'h0008, 16'h000C, 16'h0010, 16'h0014};
    for (int i = 0; i < 4; i++) begin
      check_front("release", exp_q.pop_front());
      if (i < 3) tick();
    end

    // Branch coinciding with a zero-wait response: response discarded.
    br_taken  = 1'b1;
    br_target = 16'h0010;
    tick();
    br_taken  = 1'b0;
    zero_wait = 1'b0;
    rdy_man   = 1'b0;
    check_empty("brsame");
    check("brsame_req", 32'(imem_req), 32'd1);
    check("brsame_addr", 32'(imem_addr), 32'h0010);
    tick();
    check("pend_addr", 32'(imem_addr), 32'h0010);

    // Branch while the 0x0010 request is pending; response arrives late.
    br_taken  = 1'b1;
    br_target = 16'h0100;
    tick();
    br_taken = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check("drop_addr", 32'(imem_addr), 32'h0010);
      check_empty("drop_wait");
      if (i < 2) tick();
    end
    rdy_man = 1'b1;
    tick();
    rdy_man = 1'b0;
    check_empty("dropped");
    check("redir_req", 32'(imem_req), 32'd1);
    check("redir_addr", 32'(imem_addr), 32'h0100);
    zero_wait = 1'b1;
    tick();
    check_front("redir", 16'h0100);

    // Wrap of the PC at the top of the address space.
    br_taken  = 1'b1;
    br_target = 16'hFFFC;
    tick();
    br_taken = 1'b0;
    check("wrap_addr0", 32'(imem_addr), 32'hFFFC);
    check_empty("wrap_flush");
    tick();
    check_front("wrap_top", 16'hFFFC);
    check("wrap_addr1", 32'(imem_addr), 32'h0000);
    tick();
    check_front("wrap_zero", 16'h0000);

    // Reset mid-request; a late imem_rdy must not be accepted.
    zero_wait = 1'b0;
    rdy_man   = 1'b0;
    reset     = 1'b1;
    tick();
    reset   = 1'b0;
    rdy_man = 1'b1;
    check("mrst_req", 32'(imem_req), 32'd0);
    check("mrst_addr", 32'(imem_addr), 32'h0000);
    check("mrst_state", 32'(dbg_state), 32'(IDLE));
    check_empty("mrst");
`ifdef FETCH_PERF_CNT_EN
    check("perf_fetched", perf_fetched, 32'd0);
    check("perf_flushed", perf_flushed, 32'd0);
    check("perf_stall", perf_stall, 32'd0);
`endif
    tick();
    rdy_man = 1'b0;
    check_empty("mrst_ignored");
    check("mrst_req2", 32'(imem_req), 32'd1);
    check("mrst_addr2", 32'(imem_addr), 32'h0000);
    zero_wait = 1'b1;
    tick();
    check_front("mrst_first", 16'h0000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
